// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg: EX/MEM pipeline register with valid/ready handshake,
// one-entry skid buffer, synchronous flush and saturating stall counter.
`default_nettype none

// +----------------------------------------------------------------------+
// | Module   : ex_mem_pipe_reg                                           |
// | Purpose  : EX->MEM stage register, absorbs one cycle of back-pressure |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ex_mem_pipe_reg #(
  parameter int DATA_W      = 32,
  parameter int MEM_ADDR_W  = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   ex_valid,
  output logic                   ex_ready,
  input  logic                   ex_mem_re,
  input  logic                   ex_mem_we,
  input  logic [MEM_ADDR_W-1:0]  ex_mem_addr,
  input  logic [DATA_W-1:0]      ex_mem_wdata,
  input  logic                   ex_regfile_we,
  input  logic [REG_ADDR_W-1:0]  ex_regfile_waddr,
  input  logic [DATA_W-1:0]      ex_alu_result,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic                   mem_mem_re,
  output logic                   mem_mem_we,
  output logic [MEM_ADDR_W-1:0]  mem_mem_addr,
  output logic [DATA_W-1:0]      mem_mem_wdata,
  output logic                   mem_regfile_we,
  output logic [REG_ADDR_W-1:0]  mem_regfile_waddr,
  output logic [DATA_W-1:0]      mem_data,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  // Entry layout, LSB first: alu, waddr, rf_we, wdata, addr, we, re
  localparam int c_WADDR_LSB = DATA_W;
  localparam int c_RFWE_BIT  = c_WADDR_LSB + REG_ADDR_W;
  localparam int c_WDATA_LSB = c_RFWE_BIT + 1;
  localparam int c_ADDR_LSB  = c_WDATA_LSB + DATA_W;
  localparam int c_WE_BIT    = c_ADDR_LSB + MEM_ADDR_W;
  localparam int c_RE_BIT    = c_WE_BIT + 1;
  localparam int c_ENTRY_W   = c_RE_BIT + 1;

  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_FULL  = 2'd1;
  localparam logic [1:0] c_SKID  = 2'd2;

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [c_ENTRY_W-1:0]   r_main;
  logic [c_ENTRY_W-1:0]   r_skid;
  logic [c_ENTRY_W-1:0]   w_in_entry;
  logic                   w_main_valid;
  logic                   w_skid_valid;
  logic                   w_accept;
  logic                   w_consume;
  logic                   w_load_main_in;
  logic                   w_load_main_skid;
  logic                   w_load_skid;
  logic [STALL_CNT_W-1:0] r_stall;

  assign w_in_entry = {ex_mem_re, ex_mem_we, ex_mem_addr, ex_mem_wdata,
                       ex_regfile_we, ex_regfile_waddr, ex_alu_result};

  assign w_main_valid = (r_state != c_EMPTY);
  assign w_skid_valid = (r_state == c_SKID);

  // ex_ready depends only on registered state, never on mem_ready
  assign ex_ready  = !w_skid_valid;
  assign mem_valid = w_main_valid;
  assign w_accept  = ex_valid && ex_ready;
  assign w_consume = w_main_valid && mem_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = c_EMPTY;
    end else begin
      case (r_state)
        c_EMPTY: begin
          if (w_accept) begin
            w_state_nxt    = c_FULL;
            w_load_main_in = 1'b1;
          end
        end
        c_FULL: begin
          if (w_accept && w_consume) begin
            w_load_main_in = 1'b1;
          end else if (w_consume) begin
            w_state_nxt = c_EMPTY;
          end else if (w_accept) begin
            w_state_nxt = c_SKID;
            w_load_skid = 1'b1;
          end
        end
        c_SKID: begin
          if (w_consume) begin
            w_state_nxt      = c_FULL;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = c_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main_in) begin
        r_main <= w_in_entry;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_in_entry;
      end
    end
  end

  // Counts back-pressure regardless of flush; only reset clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall <= '0;
    end else if (w_main_valid && !mem_ready && (r_stall != {STALL_CNT_W{1'b1}})) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign stall_cycles      = r_stall;
  assign mem_mem_re        = r_main[c_RE_BIT] && w_main_valid;
  assign mem_mem_we        = r_main[c_WE_BIT] && w_main_valid;
  assign mem_regfile_we    = r_main[c_RFWE_BIT] && w_main_valid;
  assign mem_mem_addr      = r_main[c_ADDR_LSB +: MEM_ADDR_W];
  assign mem_mem_wdata     = r_main[c_WDATA_LSB +: DATA_W];
  assign mem_regfile_waddr = r_main[c_WADDR_LSB +: REG_ADDR_W];
  assign mem_data          = r_main[DATA_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench for ex_mem_pipe_reg: vector table plus directed
// sequences for flush, gating, counter saturation and async reset.
`default_nettype none

module tb_ex_mem_pipe_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_mem_re = 1'b0;
  logic        ex_mem_we = 1'b0;
  logic [31:0] ex_mem_addr = '0;
  logic [31:0] ex_mem_wdata = '0;
  logic        ex_regfile_we = 1'b0;
  logic [4:0]  ex_regfile_waddr = '0;
  logic [31:0] ex_alu_result = '0;
  logic        mem_ready = 1'b0;

  logic        ex_ready, mem_valid, mem_mem_re, mem_mem_we, mem_regfile_we;
  logic [31:0] mem_mem_addr, mem_mem_wdata, mem_data;
  logic [4:0]  mem_regfile_waddr;
  logic [15:0] stall_cycles;

  logic        n_ex_ready, n_mem_valid, n_mem_re, n_mem_we, n_rf_we;
  logic [31:0] n_addr, n_wdata, n_data;
  logic [4:0]  n_waddr;
  logic [3:0]  n_stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we), .ex_mem_addr(ex_mem_addr),
    .ex_mem_wdata(ex_mem_wdata), .ex_regfile_we(ex_regfile_we),
    .ex_regfile_waddr(ex_regfile_waddr), .ex_alu_result(ex_alu_result),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_mem_re(mem_mem_re),
    .mem_mem_we(mem_mem_we), .mem_mem_addr(mem_mem_addr), .mem_mem_wdata(mem_mem_wdata),
    .mem_regfile_we(mem_regfile_we), .mem_regfile_waddr(mem_regfile_waddr),
    .mem_data(mem_data), .stall_cycles(stall_cycles)
  );

  ex_mem_pipe_reg #(.STALL_CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_ready(n_ex_ready),
    .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we), .ex_mem_addr(ex_mem_addr),
    .ex_mem_wdata(ex_mem_wdata), .ex_regfile_we(ex_regfile_we),
    .ex_regfile_waddr(ex_regfile_waddr), .ex_alu_result(ex_alu_result),
    .mem_valid(n_mem_valid), .mem_ready(mem_ready), .mem_mem_re(n_mem_re),
    .mem_mem_we(n_mem_we), .mem_mem_addr(n_addr), .mem_mem_wdata(n_wdata),
    .mem_regfile_we(n_rf_we), .mem_regfile_waddr(n_waddr),
    .mem_data(n_data), .stall_cycles(n_stall)
  );

  typedef struct {
    logic        v;
    logic [31:0] alu;
    logic        rdy;
    logic        e_valid;
    logic        e_ready;
    logic [31:0] e_data;
    int          e_stall;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_valid"}, {63'd0, mem_valid}, 64'd0);
    chk({nm, "_ready"}, {63'd0, ex_ready}, 64'd1);
    chk({nm, "_ctl"}, {61'd0, mem_mem_re, mem_mem_we, mem_regfile_we}, 64'd0);
    chk({nm, "_addr"}, {32'd0, mem_mem_addr}, 64'd0);
    chk({nm, "_wdata"}, {32'd0, mem_mem_wdata}, 64'd0);
    chk({nm, "_waddr"}, {59'd0, mem_regfile_waddr}, 64'd0);
    chk({nm, "_data"}, {32'd0, mem_data}, 64'd0);
    chk({nm, "_stall"}, {48'd0, stall_cycles}, 64'd0);
    chk({nm, "_stall4"}, {60'd0, n_stall}, 64'd0);
  endtask

  initial begin
    // stream 1..4, then back-pressure A=0x10 / B=0x20 (0x99 offered while not ready)
    vecs[0]  = '{1'b1, 32'h1,  1'b1, 1'b1, 1'b1, 32'h1,  0};
    vecs[1]  = '{1'b1, 32'h2,  1'b1, 1'b1, 1'b1, 32'h2,  0};
    vecs[2]  = '{1'b1, 32'h3,  1'b1, 1'b1, 1'b1, 32'h3,  0};
    vecs[3]  = '{1'b1, 32'h4,  1'b1, 1'b1, 1'b1, 32'h4,  0};
    vecs[4]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h4,  0};
    vecs[5]  = '{1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 32'h10, 0};
    vecs[6]  = '{1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h10, 1};
    vecs[7]  = '{1'b1, 32'h99, 1'b0, 1'b1, 1'b0, 32'h10, 2};
    vecs[8]  = '{1'b1, 32'h99, 1'b0, 1'b1, 1'b0, 32'h10, 3};
    vecs[9]  = '{1'b1, 32'h99, 1'b0, 1'b1, 1'b0, 32'h10, 4};
    vecs[10] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h20, 4};
    vecs[11] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h20, 4};

    rst = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    step();

    ex_regfile_we    = 1'b1;
    ex_regfile_waddr = 5'd7;
    for (int i = 0; i < 12; i++) begin
      ex_valid      = vecs[i].v;
      ex_alu_result = vecs[i].alu;
      mem_ready     = vecs[i].rdy;
      step();
      chk($sformatf("v%0d_valid", i), {63'd0, mem_valid}, {63'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_ready", i), {63'd0, ex_ready}, {63'd0, vecs[i].e_ready});
      chk($sformatf("v%0d_data", i), {32'd0, mem_data}, {32'd0, vecs[i].e_data});
      chk($sformatf("v%0d_rfwe", i), {63'd0, mem_regfile_we}, {63'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_stall", i), {48'd0, stall_cycles}, 64'(vecs[i].e_stall));
      chk($sformatf("v%0d_stall4", i), {60'd0, n_stall}, 64'(vecs[i].e_stall));
    end

    // Flush while in SKID; the same-cycle offer (0x32) must never appear
    ex_mem_we = 1'b1;
    ex_valid = 1'b1; ex_alu_result = 32'h30; mem_ready = 1'b0;
    step();
    ex_alu_result = 32'h31;
    step();
    chk("skid_ready", {63'd0, ex_ready}, 64'd0);
    chk("skid_stall", {48'd0, stall_cycles}, 64'd5);
    flush = 1'b1; ex_alu_result = 32'h32;
    step();
    flush = 1'b0; ex_valid = 1'b0;
    chk("flush_valid", {63'd0, mem_valid}, 64'd0);
    chk("flush_we", {63'd0, mem_mem_we}, 64'd0);
    chk("flush_rfwe", {63'd0, mem_regfile_we}, 64'd0);
    chk("flush_ready", {63'd0, ex_ready}, 64'd1);
    chk("flush_stall", {48'd0, stall_cycles}, 64'd6);
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("postflush%0d_valid", k), {63'd0, mem_valid}, 64'd0);
    end

    // Store qualifier gating: address persists, write strobe does not
    ex_valid = 1'b1; ex_mem_we = 1'b1; ex_mem_addr = 32'h100; ex_alu_result = 32'h77;
    step();
    chk("store_we", {63'd0, mem_mem_we}, 64'd1);
    chk("store_addr", {32'd0, mem_mem_addr}, 64'h100);
    ex_valid = 1'b0; ex_mem_we = 1'b0; ex_mem_addr = 32'h0;
    step();
    chk("idle_we", {63'd0, mem_mem_we}, 64'd0);
    chk("idle_addr", {32'd0, mem_mem_addr}, 64'h100);
    chk("idle_valid", {63'd0, mem_valid}, 64'd0);

    // Saturation: both counters start at 6; narrow one stops at 15
    ex_valid = 1'b1; ex_alu_result = 32'h40; mem_ready = 1'b0;
    step();
    ex_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("sat%0d_stall4", k), {60'd0, n_stall}, 64'((6 + k > 15) ? 15 : 6 + k));
    end
    chk("sat_stall16", {48'd0, stall_cycles}, 64'd26);
    chk("sat_data", {32'd0, mem_data}, 64'h40);

    // Enter SKID then assert reset between edges
    ex_valid = 1'b1; ex_alu_result = 32'h41;
    step();
    ex_valid = 1'b0;
    chk("pre_rst_ready", {63'd0, ex_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    step();
    chk_all_zero("held_rst");
    @(negedge clk);
    rst = 1'b1;
    ex_valid = 1'b1; ex_alu_result = 32'h55; mem_ready = 1'b1;
    step();
    ex_valid = 1'b0;
    chk("post_rst_data", {32'd0, mem_data}, 64'h55);
    chk("post_rst_valid", {63'd0, mem_valid}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_mem_pipe_reg.md
# ex_mem_pipe_reg

Parametrised EX/MEM pipeline register with a valid/ready handshake, a one-entry skid buffer, synchronous flush and a saturating back-pressure counter. It sits between the execute stage and the memory stage. It carries memory-access control, store data, register-file write-back control and the ALU result. Unlike a plain clocked register, it can absorb one cycle of memory-stage back-pressure without dropping an instruction, and it squashes in-flight instructions on a branch or exception flush.

## Interface
Parameters:
- DATA_W, 32, width of the ALU result and store data
- MEM_ADDR_W, 32, memory address width
- REG_ADDR_W, 5, register-file address width
- STALL_CNT_W, 16, width of the stall counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-low
- flush  in  1  squash all held instructions
- ex_valid  in  1  execute stage presents an instruction
- ex_ready  out  1  block can accept this cycle
- ex_mem_re, ex_mem_we  in  1 each  memory read / write request
- ex_mem_addr  in  MEM_ADDR_W  memory address
- ex_mem_wdata  in  DATA_W  store data
- ex_regfile_we  in  1  register write enable
- ex_regfile_waddr  in  REG_ADDR_W  destination register
- ex_alu_result  in  DATA_W  ALU result
- mem_valid  out  1  output instruction valid
- mem_ready  in  1  memory stage consumes this cycle
- mem_mem_re, mem_mem_we, mem_mem_addr, mem_mem_wdata, mem_regfile_we, mem_regfile_waddr, mem_data  out  as inputs  registered copies of the fields
- stall_cycles  out  STALL_CNT_W  saturating back-pressure count

## Operation
- Storage: one main entry drives the outputs, plus one skid entry; each entry has its own valid bit.
- Handshake terms:
  - accept = ex_valid && ex_ready
  - consume = mem_valid && mem_ready
- ex_ready = !skid_valid. It is a registered state bit, with no combinational path from mem_ready.
- mem_valid = main_valid.
- States:
  - EMPTY (main and skid invalid)
  - FULL (main valid only)
  - SKID (both valid)
- Transitions with flush low:
  - EMPTY: accept -> FULL, main loads the inputs.
  - FULL: accept && consume -> FULL, main reloads.
  - FULL: consume only -> EMPTY.
  - FULL: accept only -> SKID, skid loads the inputs.
  - FULL: neither -> hold.
  - SKID: consume -> FULL, main takes the skid contents and skid becomes invalid.
  - SKID: no consume -> hold. No accept is possible because ex_ready=0.
- Flush: at the next edge both valid bits clear and the state goes to EMPTY, from any state.
  - Flush overrides a same-cycle accept; that instruction is dropped.
  - A same-cycle consume still counts as delivered.
- Qualification: mem_mem_re, mem_mem_we and mem_regfile_we are each gated by main_valid, so all three are 0 whenever mem_valid=0.
- Unqualified data fields (address, wdata, waddr, mem_data) hold their last loaded value while invalid.
- stall_cycles increments on every cycle with mem_valid && !mem_ready. It saturates at 2^STALL_CNT_W-1. Only reset clears it; flush does not.

## Timing
- Reset (rst=0), immediate and asynchronous:
  - Both valid bits clear; state goes to EMPTY.
  - All data outputs and stall_cycles go to 0.
  - ex_ready=1 and mem_valid=0.
- Latency: an instruction accepted at edge N is visible on the outputs after edge N with mem_valid=1. This is 1 cycle.
- Throughput: 1 instruction per cycle while mem_ready stays high.
- A skid entry is delivered at the first edge where consume holds. ex_ready returns to 1 in the cycle after that edge.
- Ordering is strictly FIFO. The skid entry is never overtaken.
- Reset asserted mid-transfer discards both entries. The counter restarts from 0.

## Test plan
- Reset then stream: rst low 3 cycles, then ex_valid=1 with ex_alu_result=1,2,3,4 and mem_ready=1 -> mem_data shows 1,2,3,4 on consecutive cycles, each one cycle after its accept; ex_ready stays 1.
- Back-pressure: load A=0x10, then B=0x20 with mem_ready=0 -> state SKID and ex_ready=0. Hold for 3 cycles -> stall_cycles=4 and mem_data stays 0x10. Raise mem_ready -> 0x10 then 0x20 in order; ex_ready returns to 1.
- Flush in SKID: flush=1 for 1 cycle -> next cycle mem_valid=0, mem_mem_we=0, mem_regfile_we=0 and ex_ready=1; a same-cycle ex_valid instruction is never output.
- Qualifier gating: accept a store (we=1, addr=0x100) and consume it; then idle -> mem_mem_we=0 while mem_mem_addr still reads 0x100.
- Counter saturation: STALL_CNT_W=4 with mem_ready held at 0 for 20 cycles while valid -> stall_cycles=15 and holds there.
- Async reset mid-stall: drop rst between clock edges while in SKID -> all outputs 0 immediately, without waiting for a clock edge.
